// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: holds the instruction leaving MEM,
// waits (bounded) for load data, aligns it, drives the regfile write port and counts retirements.
module wb_stage #(
   parameter int LOAD_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [4:0]  mem_rd_addr_i,
   input  logic        mem_rd_wen_i,
   input  logic        mem_is_load_i,
   input  logic [2:0]  mem_funct3_i,
   input  logic [1:0]  mem_addr_lo_i,
   input  logic [31:0] mem_alu_result_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [4:0]  reg_addr_o,
   output logic [31:0] reg_data_o,
   output logic        reg_wen_o,
   output logic        load_err_o,
   output logic        misalign_o,
   output logic [63:0] instret_o
);

   localparam int CW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
   localparam logic [CW-1:0] WCNT_LAST = CW'(LOAD_TIMEOUT - 1);

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic        wen;
      logic        is_load;
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic [31:0] alu;
   } wb_reg_t;

   typedef enum logic {S_RUN, S_WAIT} state_t;

   wb_reg_t       wb_q;
   state_t        state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;
   logic [63:0]   instret_q;

   logic        is_lh, is_lw, mis, ld_pending, completing;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] load_data;

   // funct3 values outside the five defined loads are handled as LW
   assign is_lh = (wb_q.funct3[1:0] == 2'b01);
   assign is_lw = !(wb_q.funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
   assign mis   = wb_q.valid & wb_q.is_load &
                  ((is_lh & wb_q.off[0]) | (is_lw & (wb_q.off != 2'b00)));
   assign ld_pending = wb_q.valid & wb_q.is_load & !mis;
   assign completing = wb_q.valid & (!wb_q.is_load | (dmem_rvalid_i & !mis));

   assign b = dmem_rdata_i[8*wb_q.off +: 8];
   assign h = wb_q.off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

   always_comb begin
      load_data = dmem_rdata_i;
      case (wb_q.funct3)
         3'b000:  load_data = {{24{b[7]}}, b};
         3'b001:  load_data = {{16{h[15]}}, h};
         3'b100:  load_data = {24'd0, b};
         3'b101:  load_data = {16'd0, h};
         default: load_data = dmem_rdata_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RUN;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_RUN: begin
            if (ld_pending && !dmem_rvalid_i) begin
               state_d = S_WAIT;
               wcnt_d  = CW'(1);
            end
         end
         S_WAIT: begin
            if (dmem_rvalid_i || wcnt_q == WCNT_LAST) begin
               state_d = S_RUN;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      stall_o    = 1'b0;
      load_err_o = 1'b0;
      case (state_q)
         S_RUN:   stall_o = ld_pending & !dmem_rvalid_i;
         S_WAIT: begin
            stall_o    = !dmem_rvalid_i & (wcnt_q != WCNT_LAST);
            load_err_o = !dmem_rvalid_i & (wcnt_q == WCNT_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_q      <= '0;
         instret_q <= '0;
      end else begin
         if (completing) instret_q <= instret_q + 64'd1;
         if (!stall_o) begin
            wb_q.valid   <= mem_valid_i;
            wb_q.rd      <= mem_rd_addr_i;
            wb_q.wen     <= mem_rd_wen_i;
            wb_q.is_load <= mem_is_load_i;
            wb_q.funct3  <= mem_funct3_i;
            wb_q.off     <= mem_addr_lo_i;
            wb_q.alu     <= mem_alu_result_i;
         end
      end
   end

   assign reg_addr_o = wb_q.rd;
   assign reg_data_o = wb_q.is_load ? load_data : wb_q.alu;
   assign reg_wen_o  = wb_q.valid & wb_q.wen & (wb_q.rd != 5'd0) & completing;
   assign misalign_o = mis;
   assign instret_o  = instret_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback stage of the RV32I pipeline. It captures each instruction leaving MEM, waits for load data from data memory, and aligns and sign-extends that data. It drives the write port of the general register file (`reg_addr`, `reg_data`, `reg_wen`), stalls upstream while a load is outstanding, and keeps a 64-bit retired-instruction count for CSR use.

## Interface
- `LOAD_TIMEOUT`, default 16: maximum cycles a load may wait for `dmem_rvalid_i`, counting the first WB cycle.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `mem_valid_i`  in  1: MEM holds a valid instruction.
- `mem_rd_addr_i`  in  5: destination register.
- `mem_rd_wen_i`  in  1: instruction writes rd.
- `mem_is_load_i`  in  1: instruction is a load.
- `mem_funct3_i`  in  3: load funct3.
- `mem_addr_lo_i`  in  2: low bits of load byte address.
- `mem_alu_result_i`  in  32: result to write for non-loads.
- `dmem_rvalid_i`  in  1: data-memory read data valid this cycle.
- `dmem_rdata_i`  in  32: raw word read from data memory.
- `stall_o`  out  1: MEM and earlier stages must hold; WB does not capture.
- `reg_addr_o`  out  5: register-file write address.
- `reg_data_o`  out  32: register-file write data.
- `reg_wen_o`  out  1: register-file write enable.
- `load_err_o`  out  1: one-cycle pulse when a load times out.
- `misalign_o`  out  1: one-cycle pulse when a misaligned load is in WB.
- `instret_o`  out  64: retired-instruction counter.

## Operation
- **WB register fields:** `valid`, `rd`, `wen`, `is_load`, `funct3`, `off`, `alu`.
- **Capture:** on each rising edge with `stall_o=0`, the register loads all `mem_*` fields, and `valid` takes `mem_valid_i`. With `stall_o=1` the register holds.
- **FSM state RUN:** default state.
  - If `valid`, `is_load`, not misaligned, and `dmem_rvalid_i=0`, then `stall_o=1`, the next state is WAIT, and `wcnt` becomes 1.
- **FSM state WAIT:** `stall_o=1` until resolved.
  - `dmem_rvalid_i=1`: write back, `stall_o=0`, next state RUN.
  - Otherwise, when `wcnt=LOAD_TIMEOUT-1`: `load_err_o=1`, no write, `stall_o=0`, next state RUN.
  - Otherwise `wcnt` increments.
- **Load alignment:** `b` = byte at `off`; `h` = halfword at `off[1]`.
  - 000 (LB): sign-extended `b`.
  - 001 (LH): sign-extended `h`.
  - 010 (LW): whole word.
  - 100 (LBU): zero-extended `b`.
  - 101 (LHU): zero-extended `h`.
  - Any other funct3 value is treated as LW.
- **Misalignment:**
  - A load is misaligned if it is LH/LHU with `off[0]=1`, or LW with `off≠0`.
  - A misaligned load raises `misalign_o` for its WB cycle, writes nothing, never stalls, is not retired, and `dmem_rvalid_i` is ignored.
  - Upstream issues no memory request for a misaligned load.
- **Writeback outputs (combinational from the WB register):**
  - `reg_addr_o = rd`.
  - `reg_data_o` = aligned load data when `is_load`, otherwise `alu`.
  - `reg_wen_o = valid & wen & (rd≠0) & completing`.
  - `completing` means a non-load, or a load with `dmem_rvalid_i=1` and not misaligned.
- **Retire count:** `instret_o` increments by 1 on each edge where a valid instruction completes, whether or not it writes rd. It wraps modulo 2^64. Timed-out and misaligned loads do not count.

## Timing
- **Reset:** while `rst=0`, all WB register fields are 0, state is RUN, `wcnt=0` and `instret_o=0`. As a result every output is 0.
- **Reset mid-WAIT:** the pending load is abandoned and no write occurs.
- **ALU latency:** an ALU instruction leaving MEM at edge N drives `reg_wen_o` during cycle N..N+1. The register file commits it at edge N+1; the same-cycle read bypass in the register file covers ID reads in that cycle.
- **Load with data in its first WB cycle:** zero stall cycles.
- **Load with delayed data:** stalls k cycles when `dmem_rvalid_i` arrives k cycles late.
- **Load that never gets data:** stalls exactly `LOAD_TIMEOUT-1` cycles, and `load_err_o` is high in the `LOAD_TIMEOUT`-th cycle.
- **Stall release:** `stall_o` falls in the same cycle the load completes. The next instruction is captured at that cycle's edge, so there are no bubbles.
- **Spurious data:** `dmem_rvalid_i` while no load is in WB is ignored.
- **Empty stage:** `valid=0` gives no write, no stall and no count.

## Test plan
- **Back-to-back ALU ops:** rd=5 with 0x1234, then rd=0 with 0xFFFF.
  - Expect `reg_wen_o=1`, addr 5, data 0x1234.
  - The second op gives `reg_wen_o=0`; `instret_o` still reaches 2.
- **Load formatting with same-cycle rvalid:** rdata=0x80FF7F01.
  - LB off=3 gives 0xFFFFFF80; LBU off=1 gives 0x7F.
  - LH off=2 gives 0xFFFF80FF; LHU off=0 gives 0x7F01.
  - LW gives 0x80FF7F01.
  - No stall in any case.
- **Late rvalid:** load rd=7 with rvalid 3 cycles late.
  - `stall_o` is high for 3 cycles and the MEM inputs are held.
  - The write to x7 happens in the rvalid cycle, and the next instruction is captured at that edge.
- **Timeout:** `LOAD_TIMEOUT=4`, rvalid never arrives.
  - Stall lasts 3 cycles, then `load_err_o` pulses once.
  - No write occurs and `instret_o` is unchanged.
- **Misaligned:** LW off=2, then LH off=1.
  - `misalign_o` pulses in each WB cycle.
  - No write and no stall occur.
- **Reset mid-WAIT:** assert `rst=0` during WAIT.
  - All outputs go to 0 immediately.
  - After release, a late rvalid causes no write.
